// File: rtl/blowfish_decrypt_memory_core.sv
// Iterative two-block Blowfish decryptor reading P/S tables from
// external synchronous-read key-schedule memories.
module blowfish_decrypt_memory_core #(
  parameter int ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ct,
  output logic         ready,
  output logic         busy,
  output logic [127:0] pt,
  output logic         pt_valid,
  output logic [4:0]   p_addr,
  input  logic [31:0]  p_data,
  output logic [7:0]   s0_addr,
  output logic [7:0]   s1_addr,
  output logic [7:0]   s2_addr,
  output logic [7:0]   s3_addr,
  input  logic [31:0]  s0_data,
  input  logic [31:0]  s1_data,
  input  logic [31:0]  s2_data,
  input  logic [31:0]  s3_data
);

  typedef enum logic [2:0] {
    IDLE, RND_P, RND_S, RND_F, FIN_P1, FIN_P0, FIN_X, DONE
  } state_t;

  localparam logic [4:0] IDX_TOP = 5'(ROUNDS + 1);

  state_t        state_q, state_d;
  logic [31:0]   xl_q, xl_d;
  logic [31:0]   xr_q, xr_d;
  logic [4:0]    idx_q, idx_d;
  logic          half_q, half_d;
  logic [63:0]   ct_lo_q, ct_lo_d;
  logic [63:0]   tmp_q, tmp_d;
  logic [127:0]  pt_q, pt_d;
  logic          pt_valid_q, pt_valid_d;

  logic [31:0]   xl_p;
  logic [31:0]   f_val;

  // xL after the P-word fetched last cycle is folded in
  assign xl_p  = xl_q ^ p_data;
  assign f_val = ((s0_data + s1_data) ^ s2_data) + s3_data;

  always_comb begin
    state_d    = state_q;
    xl_d       = xl_q;
    xr_d       = xr_q;
    idx_d      = idx_q;
    half_d     = half_q;
    ct_lo_d    = ct_lo_q;
    tmp_d      = tmp_q;
    pt_d       = pt_q;
    pt_valid_d = pt_valid_q;
    p_addr     = 5'd0;
    s0_addr    = 8'd0;
    s1_addr    = 8'd0;
    s2_addr    = 8'd0;
    s3_addr    = 8'd0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ct_lo_d    = ct[63:0];
          xl_d       = ct[127:96];
          xr_d       = ct[95:64];
          idx_d      = IDX_TOP;
          half_d     = 1'b0;
          pt_valid_d = 1'b0;
          state_d    = RND_P;
        end
      end
      RND_P: begin
        p_addr  = idx_q;
        state_d = RND_S;
      end
      RND_S: begin
        xl_d    = xl_p;
        s0_addr = xl_p[31:24];
        s1_addr = xl_p[23:16];
        s2_addr = xl_p[15:8];
        s3_addr = xl_p[7:0];
        state_d = RND_F;
      end
      RND_F: begin
        xl_d = xr_q ^ f_val;
        xr_d = xl_q;
        if (idx_q == 5'd2) begin
          state_d = FIN_P1;
        end else begin
          idx_d   = idx_q - 5'd1;
          state_d = RND_P;
        end
      end
      FIN_P1: begin
        xl_d    = xr_q;
        xr_d    = xl_q;
        p_addr  = 5'd1;
        state_d = FIN_P0;
      end
      FIN_P0: begin
        xr_d    = xr_q ^ p_data;
        p_addr  = 5'd0;
        state_d = FIN_X;
      end
      FIN_X: begin
        if (!half_q) begin
          tmp_d   = {xl_p, xr_q};
          xl_d    = ct_lo_q[63:32];
          xr_d    = ct_lo_q[31:0];
          idx_d   = IDX_TOP;
          half_d  = 1'b1;
          state_d = RND_P;
        end else begin
          pt_d       = {tmp_q, xl_p, xr_q};
          pt_valid_d = 1'b1;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      xl_q       <= '0;
      xr_q       <= '0;
      idx_q      <= '0;
      half_q     <= 1'b0;
      ct_lo_q    <= '0;
      tmp_q      <= '0;
      pt_q       <= '0;
      pt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      xl_q       <= xl_d;
      xr_q       <= xr_d;
      idx_q      <= idx_d;
      half_q     <= half_d;
      ct_lo_q    <= ct_lo_d;
      tmp_q      <= tmp_d;
      pt_q       <= pt_d;
      pt_valid_q <= pt_valid_d;
    end
  end

  assign ready    = (state_q == IDLE) || (state_q == DONE);
  assign busy     = !ready;
  assign pt       = pt_q;
  assign pt_valid = pt_valid_q;

endmodule

// File: tb/tb_blowfish_decrypt_memory_core.sv
// Directed bench: external table memories, encrypt-side model
// produces ciphertexts whose decryption must return the plaintext.
module tb_blowfish_decrypt_memory_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] ct;
  logic         ready;
  logic         busy;
  logic [127:0] pt;
  logic         pt_valid;
  logic [4:0]   p_addr;
  logic [31:0]  p_data;
  logic [7:0]   s0_addr, s1_addr, s2_addr, s3_addr;
  logic [31:0]  s0_data, s1_data, s2_data, s3_data;

  blowfish_decrypt_memory_core #(.ROUNDS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ct       (ct),
    .ready    (ready),
    .busy     (busy),
    .pt       (pt),
    .pt_valid (pt_valid),
    .p_addr   (p_addr),
    .p_data   (p_data),
    .s0_addr  (s0_addr),
    .s1_addr  (s1_addr),
    .s2_addr  (s2_addr),
    .s3_addr  (s3_addr),
    .s0_data  (s0_data),
    .s1_data  (s1_data),
    .s2_data  (s2_data),
    .s3_data  (s3_data)
  );

  always #5 clk = ~clk;

  logic [31:0] p_mem [18];
  logic [31:0] s0m [256];
  logic [31:0] s1m [256];
  logic [31:0] s2m [256];
  logic [31:0] s3m [256];

  always @(posedge clk) begin
    p_data  <= (p_addr < 5'd18) ? p_mem[p_addr] : 32'hDEADBEEF;
    s0_data <= s0m[s0_addr];
    s1_data <= s1m[s1_addr];
    s2_data <= s2m[s2_addr];
    s3_data <= s3m[s3_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [4:0] addr_log [102];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mix(input logic [31:0] x);
    logic [31:0] v;
    v = x ^ 32'h243F6A88;
    v = v * 32'h9E3779B1;
    v = v ^ (v >> 15);
    v = v * 32'h85EBCA6B;
    v = v ^ (v >> 13);
    return v;
  endfunction

  task automatic fill(input bit nz);
    for (int i = 0; i < 18; i++)
      p_mem[i] = nz ? mix(32'(i)) : 32'd0;
    for (int j = 0; j < 256; j++) begin
      s0m[j] = nz ? mix(32'h100 + 32'(j)) : 32'd0;
      s1m[j] = nz ? mix(32'h200 + 32'(j)) : 32'd0;
      s2m[j] = nz ? mix(32'h300 + 32'(j)) : 32'd0;
      s3m[j] = nz ? mix(32'h400 + 32'(j)) : 32'd0;
    end
  endtask

  function automatic logic [31:0] bf_f(input logic [31:0] x);
    return ((s0m[x[31:24]] + s1m[x[23:16]]) ^ s2m[x[15:8]])
           + s3m[x[7:0]];
  endfunction

  function automatic logic [63:0] bf_enc(input logic [63:0] b);
    logic [31:0] l, r, t;
    l = b[63:32];
    r = b[31:0];
    for (int i = 0; i < 16; i++) begin
      l = l ^ p_mem[i];
      r = r ^ bf_f(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ p_mem[16];
    l = l ^ p_mem[17];
    return {l, r};
  endfunction

  function automatic logic [127:0] enc128(input logic [127:0] p);
    return {bf_enc(p[127:64]), bf_enc(p[63:0])};
  endfunction

  task automatic start_op(input logic [127:0] c);
    @(negedge clk);
    ct    = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ct    = ~c;
  endtask

  // Waits for pt_valid, logging p_addr per cycle; optional start pulse
  task automatic wait_done(input int pulse_at, input logic [127:0] pc,
                           output int lat);
    lat = 0;
    addr_log[0] = p_addr;
    while (!pt_valid && lat < 300) begin
      if (lat == pulse_at - 1) begin
        start = 1'b1;
        ct    = pc;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (lat < 102) addr_log[lat] = p_addr;
    end
  endtask

  task automatic chk_addrs(input string tag);
    int bad;
    int b;
    logic [4:0] e;
    bad = 0;
    for (int c = 0; c < 102; c++) begin
      b = c % 51;
      if (b < 48 && (b % 3) == 0) e = 5'(17 - b / 3);
      else if (b == 48) e = 5'd1;
      else if (b == 49) e = 5'd0;
      else continue;
      if (addr_log[c] !== e) bad++;
    end
    chk(tag, 128'(bad), 128'd0);
  endtask

  logic [127:0] pa, pb, pc, ca, cb, cc;
  int lat;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ct    = '0;
    fill(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pt", pt, 128'd0);
    chk("rst_pt_valid", 128'(pt_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ready", 128'(ready), 128'd1);
    chk("rst_p_addr", 128'(p_addr), 128'd0);
    chk("rst_s0_addr", 128'(s0_addr), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    start_op(128'h0123456789ABCDEF_FEDCBA9876543210);
    chk("zero_busy", 128'(busy), 128'd1);
    wait_done(0, '0, lat);
    chk("zero_latency", 128'(lat), 128'd102);
    chk("zero_pt", pt, 128'h89ABCDEF01234567_76543210FEDCBA98);
    chk("zero_ready", 128'(ready), 128'd1);
    chk_addrs("zero_addr_seq");

    fill(1'b1);
    pa = 128'h0;
    pb = {4{32'hFFFFFFFF}};
    pc = 128'h0123456789ABCDEF_FEDCBA9876543210;
    ca = enc128(pa);
    cb = enc128(pb);
    cc = enc128(pc);

    start_op(ca);
    wait_done(0, '0, lat);
    chk("vecA_latency", 128'(lat), 128'd102);
    chk("vecA_pt", pt, pa);
    chk_addrs("vecA_addr_seq");

    start_op(cb);
    wait_done(0, '0, lat);
    chk("vecB_pt", pt, pb);
    chk("vecB_valid", 128'(pt_valid), 128'd1);

    start_op(cc);
    wait_done(50, ca, lat);
    chk("busy_start_latency", 128'(lat), 128'd102);
    chk("busy_start_pt", pt, pc);
    chk_addrs("vecC_addr_seq");
    repeat (110) @(posedge clk);
    #1;
    chk("single_result_pt", pt, pc);
    chk("single_result_valid", 128'(pt_valid), 128'd1);
    chk("single_result_busy", 128'(busy), 128'd0);

    start_op(ca);
    wait_done(0, '0, lat);
    chk("b2b_first_pt", pt, pa);
    start_op(cb);
    chk("b2b_valid_drop", 128'(pt_valid), 128'd0);
    chk("b2b_pt_hold", pt, pa);
    chk("b2b_busy", 128'(busy), 128'd1);
    wait_done(0, '0, lat);
    chk("b2b_latency", 128'(lat), 128'd102);
    chk("b2b_pt", pt, pb);

    start_op(cc);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_pt", pt, 128'd0);
    chk("midrst_valid", 128'(pt_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_ready", 128'(ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    start_op(cc);
    wait_done(0, '0, lat);
    chk("postrst_latency", 128'(lat), 128'd102);
    chk("postrst_pt", pt, pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
